// File: rtl/zbuf_mem_responder.sv
// Memory-side responder for the depth-buffer request interface.
// Serves reads and writes from an on-chip word array with programmable latencies and a bulk fill.
module zbuf_mem_responder #(
    parameter int Z_SIZE        = 8,
    parameter int ADDR_SIZE     = 32,
    parameter int DEPTH         = 16,
    parameter int BASE_ADDR     = 0,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 buf_r_w,
    input  logic [ADDR_SIZE-1:0] buf_addr,
    input  logic [Z_SIZE-1:0]    buf_data_w,
    input  logic                 data_r_ready,
    output logic                 data_r_valid,
    output logic [Z_SIZE-1:0]    buf_data_r,
    input  logic                 data_w_valid,
    output logic                 data_w_ready,
    input  logic                 clear_i,
    input  logic [Z_SIZE-1:0]    clear_value_i,
    output logic                 clear_done_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int CNT_MAX = (DEPTH > 16) ? DEPTH : 16;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_SIZE-1:0] BASE_A  = ADDR_SIZE'(BASE_ADDR);
    localparam logic [ADDR_SIZE-1:0] DEPTH_A = ADDR_SIZE'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_ACK  = 3'd4,
        ST_CLEAR   = 3'd5
    } state_t;

    function automatic logic in_range_f(input logic [ADDR_SIZE-1:0] a);
        return (a >= BASE_A) && ((a - BASE_A) < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] index_f(input logic [ADDR_SIZE-1:0] a);
        return IDX_W'(a - BASE_A);
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic [ADDR_SIZE-1:0]   addr_r, addr_nxt_s;
    logic [Z_SIZE-1:0]      wdata_r, wdata_nxt_s;
    logic [Z_SIZE-1:0]      fill_r, fill_nxt_s;
    logic                   rw_r, rw_nxt_s;
    logic                   rvalid_r, rvalid_nxt_s;
    logic [Z_SIZE-1:0]      rdata_r, rdata_nxt_s;
    logic                   wready_r, wready_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   busy_r, busy_nxt_s;
    logic                   err_r, err_nxt_s;

    logic [Z_SIZE-1:0]      mem_r [DEPTH];
    logic                   mem_we_s;
    logic [IDX_W-1:0]       mem_idx_s;
    logic [Z_SIZE-1:0]      mem_wdata_s;

    // With single-cycle latency the access completes on the acceptance edge, so use live inputs there
    logic [ADDR_SIZE-1:0]   op_addr_s;
    logic [Z_SIZE-1:0]      op_data_s;
    logic                   op_in_range_s;
    logic [Z_SIZE-1:0]      op_rdata_s;

    assign op_addr_s     = (state_r == ST_IDLE) ? buf_addr : addr_r;
    assign op_data_s     = (state_r == ST_IDLE) ? buf_data_w : wdata_r;
    assign op_in_range_s = in_range_f(op_addr_s);
    assign op_rdata_s    = op_in_range_s ? mem_r[index_f(op_addr_s)] : {Z_SIZE{1'b1}};

    // Next-state and next-output logic
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        addr_nxt_s   = addr_r;
        wdata_nxt_s  = wdata_r;
        fill_nxt_s   = fill_r;
        rw_nxt_s     = rw_r;
        rvalid_nxt_s = 1'b0;
        rdata_nxt_s  = rdata_r;
        wready_nxt_s = 1'b0;
        done_nxt_s   = 1'b0;
        err_nxt_s    = err_r;
        mem_we_s     = 1'b0;
        mem_idx_s    = index_f(op_addr_s);
        mem_wdata_s  = op_data_s;
        case (state_r)
            ST_IDLE: begin
                if (clear_i) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    fill_nxt_s  = clear_value_i;
                end else if (data_w_valid && !buf_r_w) begin
                    addr_nxt_s  = buf_addr;
                    wdata_nxt_s = buf_data_w;
                    rw_nxt_s    = 1'b0;
                    if (WRITE_LATENCY <= 1) begin
                        state_nxt_s  = ST_WR_ACK;
                        wready_nxt_s = 1'b1;
                        mem_we_s     = op_in_range_s;
                        err_nxt_s    = err_r | !op_in_range_s;
                    end else begin
                        state_nxt_s = ST_WR_WAIT;
                        cnt_nxt_s   = CNT_W'(WRITE_LATENCY - 1);
                    end
                end else if (data_r_ready && buf_r_w) begin
                    addr_nxt_s = buf_addr;
                    rw_nxt_s   = 1'b1;
                    if (READ_LATENCY <= 1) begin
                        state_nxt_s  = ST_RD_RESP;
                        rvalid_nxt_s = 1'b1;
                        rdata_nxt_s  = op_rdata_s;
                        err_nxt_s    = err_r | !op_in_range_s;
                    end else begin
                        state_nxt_s = ST_RD_WAIT;
                        cnt_nxt_s   = CNT_W'(READ_LATENCY - 1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_r <= CNT_W'(1)) begin
                    state_nxt_s  = ST_RD_RESP;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    rvalid_nxt_s = 1'b1;
                    rdata_nxt_s  = op_rdata_s;
                    err_nxt_s    = err_r | !op_in_range_s;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_RD_RESP: begin
                if (data_r_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    rvalid_nxt_s = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                // Commit on the edge entering the ack cycle so an earlier reset leaves the array untouched
                if (cnt_r <= CNT_W'(1)) begin
                    state_nxt_s  = ST_WR_ACK;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                    wready_nxt_s = 1'b1;
                    mem_we_s     = !rw_r && op_in_range_s;
                    err_nxt_s    = err_r | !op_in_range_s;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_WR_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_idx_s   = IDX_W'(cnt_r);
                mem_wdata_s = fill_r;
                if (cnt_r == CNT_W'(DEPTH - 1)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    done_nxt_s  = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r    <= {CNT_W{1'b0}};
            addr_r   <= {ADDR_SIZE{1'b0}};
            wdata_r  <= {Z_SIZE{1'b0}};
            fill_r   <= {Z_SIZE{1'b0}};
            rw_r     <= 1'b0;
            rvalid_r <= 1'b0;
            rdata_r  <= {Z_SIZE{1'b0}};
            wready_r <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            addr_r   <= addr_nxt_s;
            wdata_r  <= wdata_nxt_s;
            fill_r   <= fill_nxt_s;
            rw_r     <= rw_nxt_s;
            rvalid_r <= rvalid_nxt_s;
            rdata_r  <= rdata_nxt_s;
            wready_r <= wready_nxt_s;
            done_r   <= done_nxt_s;
            busy_r   <= busy_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    // Word array: contents survive reset, but no write lands while reset is asserted
    always_ff @(posedge clk_i) begin
        if (mem_we_s && !rst_i) begin
            mem_r[mem_idx_s] <= mem_wdata_s;
        end
    end

    assign data_r_valid = rvalid_r;
    assign buf_data_r   = rdata_r;
    assign data_w_ready = wready_r;
    assign clear_done_o = done_r;
    assign busy_o       = busy_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_zbuf_mem_responder.sv
// Directed self-checking bench for zbuf_mem_responder with default parameters.
module tb_zbuf_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        buf_r_w;
    logic [31:0] buf_addr;
    logic [7:0]  buf_data_w;
    logic        data_r_ready;
    logic        data_r_valid;
    logic [7:0]  buf_data_r;
    logic        data_w_valid;
    logic        data_w_ready;
    logic        clear_i;
    logic [7:0]  clear_value_i;
    logic        clear_done_o;
    logic        busy_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model [16];

    always #5 clk_i = ~clk_i;

    zbuf_mem_responder dut (
        .clk_i(clk_i), .rst_i(rst_i), .buf_r_w(buf_r_w), .buf_addr(buf_addr),
        .buf_data_w(buf_data_w), .data_r_ready(data_r_ready), .data_r_valid(data_r_valid),
        .buf_data_r(buf_data_r), .data_w_valid(data_w_valid), .data_w_ready(data_w_ready),
        .clear_i(clear_i), .clear_value_i(clear_value_i), .clear_done_o(clear_done_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    task automatic do_write(input logic [31:0] a, input logic [7:0] d, output int lat);
        @(negedge clk_i);
        buf_r_w = 1'b0; buf_addr = a; buf_data_w = d; data_w_valid = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            data_w_valid = 1'b0; buf_addr = a + 32'd1; buf_data_w = ~d;
            if (data_w_ready) begin lat = i; break; end
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [7:0] d, output int lat);
        @(negedge clk_i);
        buf_r_w = 1'b1; buf_addr = a; data_r_ready = 1'b1;
        lat = -1; d = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            data_r_ready = 1'b0; buf_addr = a + 32'd3;
            if (data_r_valid) begin lat = i; d = buf_data_r; break; end
        end
        if (lat > 0) begin
            data_r_ready = 1'b1; buf_r_w = 1'b0;
            @(negedge clk_i);
            data_r_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; buf_r_w = 1'b0; buf_addr = 32'd0; buf_data_w = 8'h00;
        data_r_ready = 1'b0; data_w_valid = 1'b0; clear_i = 1'b0; clear_value_i = 8'h00;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({data_r_valid, data_w_ready, clear_done_o, busy_o, err_o} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000",
                {data_r_valid, data_w_ready, clear_done_o, busy_o, err_o});
        end
        n_checks++;
        if (buf_data_r !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 00", buf_data_r);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_clear(input logic [7:0] v);
        int busy_cnt, done_cnt, done_at, done_busy;
        logic [7:0] d;
        int lat;
        @(negedge clk_i);
        clear_i = 1'b1; clear_value_i = v;
        @(negedge clk_i);
        clear_i = 1'b0; clear_value_i = ~v;
        busy_cnt = 0; done_cnt = 0; done_at = -1; done_busy = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_o) busy_cnt++;
            if (clear_done_o) begin
                done_cnt++; done_at = i;
                if (busy_o) done_busy++;
            end
            @(negedge clk_i);
        end
        n_checks++;
        if (busy_cnt != 16) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 16", busy_cnt); end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt); end
        n_checks++;
        if (done_at != 16 || done_busy != 0) begin
            n_fail++; $display("FAIL clear_done_timing: got cycle %0d busy %0d expected cycle 16 busy 0", done_at, done_busy);
        end
        for (int i = 0; i < 16; i++) model[i] = v;
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i), d, lat);
            n_checks++;
            if (d !== v || lat != 2) begin
                n_fail++; $display("FAIL clear_read[%0d]: got %h lat %0d expected %h lat 2", i, d, lat, v);
            end
        end
    endtask

    task automatic test_write_read();
        int lat;
        logic [7:0] d;
        do_write(32'd5, 8'h3C, lat); model[5] = 8'h3C;
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL write_latency: got %0d expected 1", lat); end
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b expected 0", err_o); end
        do_read(32'd5, d, lat);
        n_checks++;
        if (lat != 2) begin n_fail++; $display("FAIL read_latency: got %0d expected 2", lat); end
        n_checks++;
        if (d !== 8'h3C) begin n_fail++; $display("FAIL read_data: got %h expected 3c", d); end
        do_write(32'd15, 8'hA5, lat); model[15] = 8'hA5;
        do_read(32'd15, d, lat);
        n_checks++;
        if (d !== 8'hA5 || lat != 2) begin n_fail++; $display("FAIL read_top_word: got %h lat %0d expected a5 lat 2", d, lat); end
        do_read(32'd0, d, lat);
        n_checks++;
        if (d !== model[0]) begin n_fail++; $display("FAIL read_word0: got %h expected %h", d, model[0]); end
    endtask

    task automatic test_backpressure();
        int found;
        @(negedge clk_i);
        buf_r_w = 1'b1; buf_addr = 32'd5; data_r_ready = 1'b1;
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_i);
            data_r_ready = 1'b0; buf_addr = 32'd9;
            if (data_r_valid) begin found = i; break; end
        end
        n_checks++;
        if (found != 2) begin n_fail++; $display("FAIL bp_latency: got %0d expected 2", found); end
        for (int k = 0; k <= 4; k++) begin
            n_checks++;
            if (data_r_valid !== 1'b1 || buf_data_r !== 8'h3C) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got valid %b data %h expected valid 1 data 3c", k, data_r_valid, buf_data_r);
            end
            if (k < 4) @(negedge clk_i);
        end
        data_r_ready = 1'b1; buf_r_w = 1'b0;
        @(negedge clk_i);
        data_r_ready = 1'b0;
        n_checks++;
        if (data_r_valid !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got valid %b busy %b expected 0 0", data_r_valid, busy_o);
        end
    endtask

    task automatic test_range();
        int lat;
        logic [7:0] d;
        do_write(32'd16, 8'h11, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL range_write_ack: got lat %0d expected 1", lat); end
        n_checks++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL range_err_set: got %b expected 1", err_o); end
        do_read(32'd20, d, lat);
        n_checks++;
        if (d !== 8'hFF || lat != 2) begin n_fail++; $display("FAIL range_read: got %h lat %0d expected ff lat 2", d, lat); end
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i), d, lat);
            n_checks++;
            if (d !== model[i]) begin n_fail++; $display("FAIL range_array[%0d]: got %h expected %h", i, d, model[i]); end
        end
        n_checks++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL range_err_sticky: got %b expected 1", err_o); end
    endtask

    task automatic test_reset_mid_write();
        int seen;
        int lat;
        logic [7:0] d;
        @(negedge clk_i);
        rst_i = 1'b1; buf_r_w = 1'b0; buf_addr = 32'd5; buf_data_w = 8'hAA; data_w_valid = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; data_w_valid = 1'b0;
        n_checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL rstw_state: got err %b busy %b expected 0 0", err_o, busy_o);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (data_w_ready) seen++;
            @(negedge clk_i);
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rstw_no_ack: got %0d acks expected 0", seen); end
        do_read(32'd5, d, lat);
        n_checks++;
        if (d !== 8'h3C) begin n_fail++; $display("FAIL rstw_word: got %h expected 3c", d); end
    endtask

    task automatic test_priority();
        int lat, seen, done;
        logic [7:0] d;
        do_write(32'd3, 8'h5A, lat); model[3] = 8'h5A;
        @(negedge clk_i);
        clear_i = 1'b1; clear_value_i = 8'h77;
        data_w_valid = 1'b1; buf_r_w = 1'b0; buf_addr = 32'd3; buf_data_w = 8'h99; data_r_ready = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0; data_w_valid = 1'b0; data_r_ready = 1'b0;
        seen = 0; done = 0;
        for (int i = 0; i < 40 && done == 0; i++) begin
            if (data_w_ready) seen++;
            if (clear_done_o) done = 1;
            else @(negedge clk_i);
        end
        n_checks++;
        if (done != 1 || seen != 0) begin
            n_fail++; $display("FAIL prio_clear_taken: got done %0d acks %0d expected 1 0", done, seen);
        end
        for (int i = 0; i < 16; i++) model[i] = 8'h77;
        do_read(32'd3, d, lat);
        n_checks++;
        if (d !== 8'h77) begin n_fail++; $display("FAIL prio_word3: got %h expected 77", d); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [7:0] d;
        for (int k = 0; k < 3; k++) begin
            do_write(32'd7, 8'h40 + 8'(k), lat);
            do_read(32'd7, d, lat);
            n_checks++;
            if (d !== 8'h40 + 8'(k)) begin
                n_fail++; $display("FAIL b2b_read[%0d]: got %h expected %h", k, d, 8'h40 + 8'(k));
            end
        end
        do_read(32'd8, d, lat);
        n_checks++;
        if (d !== model[8]) begin n_fail++; $display("FAIL b2b_neighbour: got %h expected %h", d, model[8]); end
    endtask

    initial begin
        test_reset();
        test_clear(8'hFF);
        test_write_read();
        test_backpressure();
        test_range();
        test_reset_mid_write();
        test_priority();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
